// File: rtl/edge_detector_pkg.sv
// edge_detector_pkg: shared mode encodings and counter sizing helper for the edge detector
// Contents:
//   MODE_OFF/MODE_RISE/MODE_FALL/MODE_BOTH - per-channel edge select encodings
//   cnt_width(n) - smallest width w >= 1 with 2**w >= n
package edge_detector_pkg;
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic int cnt_width(input int n);
        for (int w = 1; w < 31; w++)
            if ((1 << w) >= n) return w;
        return 31;
    endfunction
endpackage

// File: rtl/edge_channel.sv
// edge_channel: one channel of synchroniser, debouncer, edge qualifier, pending flag and event counter
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_warmup      - while high, level follows sync directly with no events
//   i_signl       - raw asynchronous input
//   i_mode        - edge select (off/rise/fall/both)
//   i_ack         - clears the pending flag
//   i_clr_cnt     - clears the event counter
//   o_outedge     - registered one-cycle event pulse
//   o_level       - debounced level
//   o_pending     - sticky event flag
//   o_event_cnt   - saturating event counter
module edge_channel
    import edge_detector_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_warmup,
    input  logic             i_signl,
    input  logic [1:0]       i_mode,
    input  logic             i_ack,
    input  logic             i_clr_cnt,
    output logic             o_outedge,
    output logic             o_level,
    output logic             o_pending,
    output logic [CNT_W-1:0] o_event_cnt
);
    localparam int D  = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int DW = cnt_width(D);
    localparam logic [DW-1:0]    D_LAST  = DW'(D - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_samp;
    logic [DW-1:0]          r_db;
    logic                   r_level;
    logic                   r_outedge;
    logic                   r_pending;
    logic [CNT_W-1:0]       r_cnt;
    logic                   w_diff;
    logic                   w_accept;
    logic                   w_rise_en;
    logic                   w_fall_en;
    logic                   w_pulse;

    // r_samp is a sampling stage between the synchroniser and the debouncer,
    // giving a level/outedge latency of SYNC_STAGES + D edges
    assign w_diff    = r_samp != r_level;
    assign w_accept  = !i_warmup && w_diff && (r_db == D_LAST);
    assign w_rise_en = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);
    assign w_fall_en = (i_mode == MODE_FALL) || (i_mode == MODE_BOTH);
    assign w_pulse   = w_accept && (r_samp ? w_rise_en : w_fall_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_samp    <= 1'b0;
            r_db      <= '0;
            r_level   <= 1'b0;
            r_outedge <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_signl};
            r_samp    <= r_sync[SYNC_STAGES-1];
            r_db      <= (i_warmup || !w_diff || w_accept) ? '0 : r_db + DW'(1);
            // warm-up loads the level straight from the synchroniser so a line
            // held high through reset never looks like a rising edge
            r_level   <= i_warmup ? r_sync[SYNC_STAGES-1] : (w_accept ? r_samp : r_level);
            r_outedge <= w_pulse;
            r_pending <= w_pulse || (r_pending && !i_ack);
            r_cnt     <= i_clr_cnt ? CNT_W'(w_pulse) :
                         (w_pulse && r_cnt != CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;
        end
    end

    assign o_outedge   = r_outedge;
    assign o_level     = r_level;
    assign o_pending   = r_pending;
    assign o_event_cnt = r_cnt;
endmodule

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: multi-channel synchronising, debouncing edge detector with pending flags and event counters
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   i_signl       - raw asynchronous inputs, bit i = channel i
//   i_mode        - per-channel edge select at [2i+1:2i]
//   i_ack         - per-channel pending clear
//   i_clr_cnt     - per-channel event counter clear
//   o_outedge     - per-channel one-cycle event pulses
//   o_level       - per-channel debounced levels
//   o_pending     - per-channel sticky event flags
//   o_event_cnt   - per-channel saturating counters at [CNT_W*i +: CNT_W]
module edge_detector_multi
    import edge_detector_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       i_signl,
    input  logic [2*CHANNELS-1:0]     i_mode,
    input  logic [CHANNELS-1:0]       i_ack,
    input  logic [CHANNELS-1:0]       i_clr_cnt,
    output logic [CHANNELS-1:0]       o_outedge,
    output logic [CHANNELS-1:0]       o_level,
    output logic [CHANNELS-1:0]       o_pending,
    output logic [CHANNELS*CNT_W-1:0] o_event_cnt
);
    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = cnt_width(WARM + 1);

    logic [WW-1:0] r_warm;
    logic          w_warmup_active;

    // one shared warm-up window covers the time the synchronisers need to fill
    assign w_warmup_active = r_warm != '0;

    always_ff @(posedge clk) begin
        if (rst) r_warm <= WW'(WARM);
        else if (w_warmup_active) r_warm <= r_warm - WW'(1);
    end

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            edge_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_warmup   (w_warmup_active),
                .i_signl    (i_signl[g]),
                .i_mode     (i_mode[2*g +: 2]),
                .i_ack      (i_ack[g]),
                .i_clr_cnt  (i_clr_cnt[g]),
                .o_outedge  (o_outedge[g]),
                .o_level    (o_level[g]),
                .o_pending  (o_pending[g]),
                .o_event_cnt(o_event_cnt[CNT_W*g +: CNT_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_edge_detector_multi.sv
// tb_edge_detector_multi: self-checking bench with vector table, pulse scoreboard and corner sequences
module tb_edge_detector_multi;
    typedef struct {
        logic [7:0] mode;
        logic [3:0] signl;
        logic [3:0] edg;
        logic [3:0] level;
        logic [3:0] pend;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] bits;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] signl;
    logic [7:0] mode;
    logic [3:0] ack;
    logic [3:0] clr_cnt;
    logic [3:0] outedge;
    logic [3:0] level;
    logic [3:0] pending;
    logic [7:0] event_cnt;

    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;
    exp_t sbq[$];
    vec_t vecs[8];

    edge_detector_multi #(
        .CHANNELS       (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_signl    (signl),
        .i_mode     (mode),
        .i_ack      (ack),
        .i_clr_cnt  (clr_cnt),
        .o_outedge  (outedge),
        .o_level    (level),
        .o_pending  (pending),
        .o_event_cnt(event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h at edge %0d", name, act, req, ecnt);
        end
    endtask

    // expected pulse lands 7 edges after a negedge drive: 1 to capture, then SYNC_STAGES + D
    task automatic expect_at(input int due, input logic [3:0] bits);
        exp_t e;
        if (bits == 4'b0) return;
        if (sbq.size() != 0 && sbq[sbq.size()-1].due == due)
            sbq[sbq.size()-1].bits = sbq[sbq.size()-1].bits | bits;
        else begin
            e.due  = due;
            e.bits = bits;
            sbq.push_back(e);
        end
    endtask

    task automatic apply(input logic [3:0] s, input int hold, input logic [3:0] exp_edge);
        signl = s;
        expect_at(ecnt + 7, exp_edge);
        repeat (hold) @(negedge clk);
    endtask

    task automatic pulse_ctl(input logic [3:0] a, input logic [3:0] c);
        ack     = a;
        clr_cnt = c;
        @(negedge clk);
        ack     = 4'b0;
        clr_cnt = 4'b0;
    endtask

    always @(posedge clk) begin
        #1;
        ecnt++;
        if (sbq.size() != 0 && sbq[0].due == ecnt) begin
            checks++;
            if (outedge !== sbq[0].bits) begin
                errors++;
                $display("FAIL pulse got %b required %b at edge %0d", outedge, sbq[0].bits, ecnt);
            end
            void'(sbq.pop_front());
        end else if (outedge !== 4'b0) begin
            checks++;
            errors++;
            $display("FAIL spurious_pulse got %b required 0000 at edge %0d", outedge, ecnt);
        end
    end

    initial begin
        vecs[0] = '{8'hED, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 8'h01};
        vecs[1] = '{8'hED, 4'b0101, 4'b0000, 4'b0101, 4'b0001, 8'h01};
        vecs[2] = '{8'hED, 4'b0001, 4'b0100, 4'b0001, 4'b0101, 8'h11};
        vecs[3] = '{8'hED, 4'b0000, 4'b0000, 4'b0000, 4'b0101, 8'h11};
        vecs[4] = '{8'hED, 4'b1010, 4'b1010, 4'b1010, 4'b1111, 8'h55};
        vecs[5] = '{8'hED, 4'b0000, 4'b1010, 4'b0000, 4'b1111, 8'h99};
        vecs[6] = '{8'hEC, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 8'h99};
        vecs[7] = '{8'hEC, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 8'h99};

        rst = 1'b1; signl = 4'b0; mode = 8'h00; ack = 4'b0; clr_cnt = 4'b0;
        repeat (3) @(negedge clk);
        chk("reset_outedge", {4'b0, outedge}, 8'h00);
        chk("reset_level", {4'b0, level}, 8'h00);
        chk("reset_pending", {4'b0, pending}, 8'h00);
        chk("reset_cnt", event_cnt, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            apply(vecs[i].signl, 10, vecs[i].edg);
            chk($sformatf("v%0d_level", i), {4'b0, level}, {4'b0, vecs[i].level});
            chk($sformatf("v%0d_pending", i), {4'b0, pending}, {4'b0, vecs[i].pend});
            chk($sformatf("v%0d_cnt", i), event_cnt, vecs[i].cnt);
        end

        pulse_ctl(4'hF, 4'hF);
        chk("clear_pending", {4'b0, pending}, 8'h00);
        chk("clear_cnt", event_cnt, 8'h00);

        mode = 8'hFF;
        signl = 4'b0010;
        repeat (3) @(negedge clk);
        signl = 4'b0000;
        repeat (10) @(negedge clk);
        chk("glitch_level", {4'b0, level}, 8'h00);
        chk("glitch_cnt", event_cnt, 8'h00);
        chk("glitch_pending", {4'b0, pending}, 8'h00);

        apply(4'b0010, 4, 4'b0010);
        apply(4'b0000, 10, 4'b0010);
        chk("minpulse_level", {4'b0, level}, 8'h00);
        chk("minpulse_cnt", event_cnt, 8'h08);
        chk("minpulse_pending", {4'b0, pending}, 8'h02);

        pulse_ctl(4'hF, 4'hF);
        apply(4'b1111, 10, 4'b1111);
        chk("all_level", {4'b0, level}, 8'h0F);
        chk("all_pending", {4'b0, pending}, 8'h0F);
        chk("all_cnt", event_cnt, 8'h55);
        apply(4'b1110, 6, 4'b0001);
        pulse_ctl(4'b0101, 4'b0000);
        chk("ack_race_pending", {4'b0, pending}, 8'h0B);
        chk("ack_race_cnt", event_cnt, 8'h56);
        repeat (4) @(negedge clk);

        pulse_ctl(4'b0000, 4'b1000);
        chk("clr3_cnt", event_cnt, 8'h16);
        for (int i = 0; i < 5; i++)
            apply((i % 2 == 0) ? 4'b0110 : 4'b1110, 10, 4'b1000);
        chk("sat_cnt", event_cnt, 8'hD6);
        apply(4'b1110, 6, 4'b1000);
        pulse_ctl(4'b0000, 4'b1000);
        chk("clr_pulse_cnt", event_cnt, 8'h56);
        repeat (4) @(negedge clk);

        signl = 4'hF;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst2_outedge", {4'b0, outedge}, 8'h00);
        chk("rst2_level", {4'b0, level}, 8'h00);
        chk("rst2_pending", {4'b0, pending}, 8'h00);
        chk("rst2_cnt", event_cnt, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("warm_level_2", {4'b0, level}, 8'h00);
        @(negedge clk);
        chk("warm_level_3", {4'b0, level}, 8'h0F);
        repeat (8) @(negedge clk);
        chk("warm_pending", {4'b0, pending}, 8'h00);
        chk("warm_cnt", event_cnt, 8'h00);

        signl = 4'h0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_outedge", {4'b0, outedge}, 8'h00);
        chk("mid_rst_level", {4'b0, level}, 8'h00);
        chk("mid_rst_pending", {4'b0, pending}, 8'h00);
        chk("mid_rst_cnt", event_cnt, 8'h00);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("post_rst_level", {4'b0, level}, 8'h00);
        chk("scoreboard_empty", 8'(sbq.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
